// File: rtl/complementador_a_2_serie_pkg.sv
// Shared types and sizing helpers for the bit-serial two's-complement block.
package complementador_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int unsigned WIDTH_DEF = 4;

   function automatic int unsigned cnt_w(input int unsigned w);
      return $clog2(w);
   endfunction

endpackage

// File: rtl/complementador_a_2_serie_if.sv
// Start/done handshake and operand/result bus of the serial complementer.
interface complementador_a_2_serie_if
   import complementador_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
);

   logic             start;
   logic [WIDTH-1:0] ABCD;
   logic [WIDTH-1:0] wxyz;
   logic             busy;
   logic             done;
   logic             overflow;

   modport master (
      output start, ABCD,
      input  wxyz, busy, done, overflow
   );

   modport slave (
      input  start, ABCD,
      output wxyz, busy, done, overflow
   );

endinterface

// File: rtl/complementador_a_2_serie_celda.sv
// One-bit complement cell: copy bits up to the first 1, invert everything above it.
module celda_complemento_serie (
   input  logic b,
   input  logic seen_one_in,
   output logic out_bit,
   output logic seen_one_out
);

   assign out_bit      = seen_one_in ? ~b : b;
   assign seen_one_out = seen_one_in | b;

endmodule

// File: rtl/complementador_a_2_serie.sv
// Bit-serial two's complement, LSB first, with start/done handshake and registered result.
module complementador_a_2_serie
   import complementador_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input logic clk,
   input logic rst,
   complementador_a_2_serie_if.slave bus
);

   localparam int unsigned      CW      = cnt_w(WIDTH);
   localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state;
   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] res;
   logic [CW-1:0]    count;
   logic             seen_one;
   logic             ovf_pend;
   logic             out_bit;
   logic             seen_next;

   celda_complemento_serie u_celda (
      .b            (sreg[0]),
      .seen_one_in  (seen_one),
      .out_bit      (out_bit),
      .seen_one_out (seen_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         sreg         <= '0;
         res          <= '0;
         count        <= '0;
         seen_one     <= 1'b0;
         ovf_pend     <= 1'b0;
         bus.wxyz     <= '0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  sreg     <= bus.ABCD;
                  seen_one <= 1'b0;
                  count    <= '0;
                  // Overflow flag is captured with the operand so later ABCD changes cannot affect it
                  ovf_pend <= (bus.ABCD == MIN_NEG);
                  bus.busy <= 1'b1;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               sreg     <= sreg >> 1;
               res      <= {out_bit, res[WIDTH-1:1]};
               seen_one <= seen_next;
               count    <= count + 1'b1;
               if (count == LAST) begin
                  bus.wxyz     <= {out_bit, res[WIDTH-1:1]};
                  bus.overflow <= ovf_pend;
                  bus.busy     <= 1'b0;
                  bus.done     <= 1'b1;
                  state        <= DONE;
               end
            end
            DONE: begin
               bus.done <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               bus.busy <= 1'b0;
               bus.done <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule
